branch_resolve_predict: RTL and testbench
=========================================

Name: branch_resolve_predict

Overview:
Parametrised successor to the single-cycle branch decision logic, for the pipelined core.
- Fetch side: per-PC taken prediction from a bimodal history table (BHT) of 2-bit saturating counters.
- Execute side: resolves all six RV32I conditional branches plus jumps from ALU flags, trains the BHT, and flags mispredictions with the redirect PC.
- Feeds the fetch-stage PC mux and the pipeline flush logic.

Parameters:
- XLEN, 32, PC and target width.
- BHT_ENTRIES, 64, number of counters; power of two, minimum 2; index bits IDX = log2(BHT_ENTRIES).
- COUNTER_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc_f  in  XLEN  fetch-stage PC.
- pred_taken_f  out  1  prediction for pc_f.
- resolve_valid  in  1  execute-stage instruction valid.
- pc_e  in  XLEN  execute-stage PC.
- target_e  in  XLEN  computed branch/jump target.
- branch_e  in  1  conditional branch in execute.
- jump_e  in  1  jal/jalr in execute.
- funct3_e  in  3  branch funct3.
- zero_flag  in  1  ALU zero (rs1 == rs2).
- less_than_flag  in  1  signed rs1 < rs2.
- unsign_less_than_flag  in  1  unsigned rs1 < rs2.
- pred_taken_e  in  1  prediction carried down the pipe for this instruction.
- actual_taken  out  1  resolved outcome.
- mispredict  out  1  redirect/flush request.
- redirect_pc  out  XLEN  PC to fetch on mispredict.
- illegal_branch  out  1  branch_e with reserved funct3.

Behaviour:
- Index: idx(pc) = pc[IDX+1:2]; pc[1:0] ignored.
- Prediction (combinational): pred_taken_f = BHT[idx(pc_f)][1].
- Resolution (combinational, qualified by resolve_valid):
  - funct3 000 beq: zero_flag.
  - 001 bne: ~zero_flag.
  - 100 blt: less_than_flag.
  - 101 bge: ~less_than_flag.
  - 110 bltu: unsign_less_than_flag.
  - 111 bgeu: ~unsign_less_than_flag.
  - 010/011: not taken, illegal_branch=1.
- jump_e=1: actual_taken=1 regardless of funct3; jump_e has priority over branch_e if both are high.
- resolve_valid=0, or neither branch_e nor jump_e: actual_taken=0, mispredict=0, illegal_branch=0.
- mispredict = resolve_valid & (branch_e|jump_e) & (actual_taken != pred_taken_e); forced 0 for illegal branches.
- redirect_pc = actual_taken ? target_e : pc_e + 4, modulo 2^XLEN (wraps at top of address space). Don't-care when mispredict=0.
- BHT training, at clock edge when resolve_valid & branch_e & ~jump_e & legal funct3:
  - counter at idx(pc_e) increments if taken, decrements if not.
  - saturates at 2'b11 and 2'b00.
  - jumps and illegal branches never train.
- Same-cycle read/write of one index: pred_taken_f returns the pre-update value; no bypass.
- Reset: all BHT entries = COUNTER_INIT; all outputs are combinational from state/inputs, so after reset pred_taken_f = COUNTER_INIT[1] for every PC.
- Reset asserted mid-update: update discarded, table is COUNTER_INIT while reset is high.
- No latency beyond combinational; training visible to prediction on the cycle after the edge.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined:
  - adds input stats_clr (1) and outputs branch_count (32) and mispredict_count (32).
  - branch_count increments on each resolve_valid & (branch_e|jump_e) edge.
  - mispredict_count increments on each mispredict edge.
  - both saturate at 32'hFFFFFFFF; reset or stats_clr zeroes them, stats_clr has priority over increment.
- Not defined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset, pc_f=0x100 -> pred_taken_f=0; repeat at pc_f=0xFFC -> 0 (all entries 01).
- Three beq at pc_e=0x40, zero_flag=1, pred_taken_e=0, target_e=0x80:
  - cycle 1: mispredict=1, redirect_pc=0x80.
  - counter sequence 01->10->11->11 (saturates).
  - pred_taken_f at pc_f=0x40 becomes 1 after first edge.
- bge, zero_flag=1, less_than_flag=0, pred_taken_e=1 -> actual_taken=1, mispredict=0.
- bltu not taken at pc_e=0xFFFFFFFC, pred_taken_e=1 -> mispredict=1, redirect_pc=0x00000000.
- Same-cycle index conflict, pc_f=pc_e=0x40, counter 01, taken resolve -> pred_taken_f=0 that cycle, 1 next cycle.
- branch_e with funct3=010 -> illegal_branch=1, actual_taken=0, BHT unchanged.
- jal with pred_taken_e=0 -> mispredict=1, BHT unchanged.
- Reset pulse mid-training -> all entries back to 01.
- With BRANCH_STATS_EN: 5 branches, 2 mispredicts -> counts 5/2; stats_clr -> 0/0.

Source files
------------

// File: rtl/branch_resolve_predict.sv
// Bimodal (2-bit counter) branch predictor with execute-stage resolution of RV32I branches and jumps.
// Define BRANCH_STATS_EN to add saturating branch/mispredict counters cleared by stats_clr.
module branch_resolve_predict #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BHT_ENTRIES  = 64,
    parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] target_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic [2:0]      funct3_e,
    input  logic            zero_flag,
    input  logic            less_than_flag,
    input  logic            unsign_less_than_flag,
    input  logic            pred_taken_e,
    output logic            actual_taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal_branch
`ifdef BRANCH_STATS_EN
    ,
    input  logic            stats_clr,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
`endif
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);

    logic [1:0]     bht [BHT_ENTRIES];
    logic [IDX-1:0] idx_f;
    logic [IDX-1:0] idx_e;
    logic           cond_taken;
    logic           cond_legal;
    logic           train;
    logic           unused_pc_bits;

    assign idx_f = pc_f[IDX+1:2];
    assign idx_e = pc_e[IDX+1:2];
    assign unused_pc_bits = ^{pc_f[1:0], pc_f[XLEN-1:IDX+2], pc_e[1:0], pc_e[XLEN-1:IDX+2]};

    assign pred_taken_f = bht[idx_f][1];

    always_comb begin
        cond_taken = 1'b0;
        cond_legal = 1'b1;
        case (funct3_e)
            3'b000:  cond_taken = zero_flag;
            3'b001:  cond_taken = ~zero_flag;
            3'b100:  cond_taken = less_than_flag;
            3'b101:  cond_taken = ~less_than_flag;
            3'b110:  cond_taken = unsign_less_than_flag;
            3'b111:  cond_taken = ~unsign_less_than_flag;
            default: cond_legal = 1'b0;
        endcase
    end

    // Jumps win over branches; a reserved funct3 is only flagged when no jump is present.
    always_comb begin
        actual_taken   = 1'b0;
        illegal_branch = 1'b0;
        if (resolve_valid) begin
            if (jump_e) begin
                actual_taken = 1'b1;
            end else if (branch_e) begin
                actual_taken   = cond_legal & cond_taken;
                illegal_branch = ~cond_legal;
            end
        end
    end

    assign mispredict  = resolve_valid & (branch_e | jump_e) & ~illegal_branch
                         & (actual_taken != pred_taken_e);
    assign redirect_pc = actual_taken ? target_e : pc_e + XLEN'(4);
    assign train       = resolve_valid & branch_e & ~jump_e & cond_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= COUNTER_INIT;
            end
        end else if (train) begin
            if (cond_taken && bht[idx_e] != 2'b11) begin
                bht[idx_e] <= bht[idx_e] + 2'd1;
            end else if (!cond_taken && bht[idx_e] != 2'b00) begin
                bht[idx_e] <= bht[idx_e] - 2'd1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (stats_clr) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve_valid && (branch_e || jump_e) && branch_count != '1) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Randomized and directed bench for branch_resolve_predict against an operand-level reference model.
// Stats checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_resolve_predict;

    localparam int NENT = 64;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic        resolve_valid;
    logic [31:0] pc_e;
    logic [31:0] target_e;
    logic        branch_e;
    logic        jump_e;
    logic [2:0]  funct3_e;
    logic        zero_flag;
    logic        less_than_flag;
    logic        unsign_less_than_flag;
    logic        pred_taken_e;
    logic        actual_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        illegal_branch;
`ifdef BRANCH_STATS_EN
    logic        stats_clr;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    int total = 0;
    int bad   = 0;
    int model [NENT];

    branch_resolve_predict #(
        .XLEN(32),
        .BHT_ENTRIES(NENT),
        .COUNTER_INIT(2'b01)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_f(pc_f),
        .pred_taken_f(pred_taken_f),
        .resolve_valid(resolve_valid),
        .pc_e(pc_e),
        .target_e(target_e),
        .branch_e(branch_e),
        .jump_e(jump_e),
        .funct3_e(funct3_e),
        .zero_flag(zero_flag),
        .less_than_flag(less_than_flag),
        .unsign_less_than_flag(unsign_less_than_flag),
        .pred_taken_e(pred_taken_e),
        .actual_taken(actual_taken),
        .mispredict(mispredict),
        .redirect_pc(redirect_pc),
        .illegal_branch(illegal_branch)
`ifdef BRANCH_STATS_EN
        ,
        .stats_clr(stats_clr),
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic bit is_legal(input logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

    // Outcome from the comparison each mnemonic names, expressed through the flag meanings.
    function automatic bit outcome(input logic [2:0] f3, input logic z, input logic lt, input logic ult);
        case (f3)
            3'b000:  return z;         // beq: equal
            3'b001:  return !z;        // bne
            3'b100:  return lt;        // blt
            3'b101:  return !lt;       // bge
            3'b110:  return ult;       // bltu
            3'b111:  return !ult;      // bgeu
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_pred(input logic [31:0] pc);
        return model[idx_of(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) model[i] = 1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic br, input logic jp, input logic [2:0] f3,
                         input logic z, input logic lt, input logic ult, input logic pe);
        resolve_valid = rv; pc_e = pc; target_e = tgt; branch_e = br; jump_e = jp;
        funct3_e = f3; zero_flag = z; less_than_flag = lt; unsign_less_than_flag = ult;
        pred_taken_e = pe;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock edge; the model trains from the inputs present at that edge.
    task automatic tick();
        bit do_train;
        bit t;
        int i;
        do_train = resolve_valid && branch_e && !jump_e && is_legal(funct3_e);
        t = outcome(funct3_e, zero_flag, less_than_flag, unsign_less_than_flag);
        i = idx_of(pc_e);
        @(posedge clk);
        if (reset) model_reset();
        else if (do_train) model[i] = t ? ((model[i] < 3) ? model[i] + 1 : 3)
                                        : ((model[i] > 0) ? model[i] - 1 : 0);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        model_reset();
        pc_f = 32'h100;
        #1;
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL reset_pred_100 got=%b exp=0", pred_taken_f); end
        total++; if ({actual_taken, mispredict, illegal_branch} !== 3'b000) begin bad++; $display("FAIL reset_outputs got=%b exp=000", {actual_taken, mispredict, illegal_branch}); end
        pc_f = 32'hFFC;
        #1;
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL reset_pred_ffc got=%b exp=0", pred_taken_f); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_beq_saturate();
        pc_f = 32'h40;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            total++; if (actual_taken !== 1'b1) begin bad++; $display("FAIL beq_taken[%0d] got=%b exp=1", k, actual_taken); end
            if (k == 0) begin
                total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL beq_mispredict got=%b exp=1", mispredict); end
                total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL beq_redirect got=%h exp=00000080", redirect_pc); end
            end
            tick();
            total++; if (pred_taken_f !== model_pred(32'h40)) begin bad++; $display("FAIL beq_pred_after[%0d] got=%b exp=%b", k, pred_taken_f, model_pred(32'h40)); end
        end
        // Two not-taken resolves walk a saturated counter 11->10->01.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
            #1;
            tick();
            total++; if (pred_taken_f !== model_pred(32'h40)) begin bad++; $display("FAIL beq_unwind[%0d] got=%b exp=%b", k, pred_taken_f, model_pred(32'h40)); end
        end
        idle();
    endtask

    task automatic test_bge();
        drive(1'b1, 32'h200, 32'h300, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (actual_taken !== 1'b1) begin bad++; $display("FAIL bge_taken got=%b exp=1", actual_taken); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL bge_mispredict got=%b exp=0", mispredict); end
        tick();
        idle();
    endtask

    task automatic test_bltu_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        total++; if (actual_taken !== 1'b0) begin bad++; $display("FAIL bltu_taken got=%b exp=0", actual_taken); end
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL bltu_mispredict got=%b exp=1", mispredict); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL bltu_redirect got=%h exp=00000000", redirect_pc); end
        tick();
        idle();
    endtask

    task automatic test_same_cycle();
        reset_pulse();
        pc_f = 32'h40;
        drive(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL same_cycle_before got=%b exp=0", pred_taken_f); end
        tick();
        idle();
        #1;
        total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL same_cycle_after got=%b exp=1", pred_taken_f); end
    endtask

    task automatic test_illegal();
        logic [2:0] f3;
        pc_f = 32'h40;
        for (int k = 0; k < 2; k++) begin
            f3 = (k == 0) ? 3'b010 : 3'b011;
            drive(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, f3, 1'b0, 1'b1, 1'b1, 1'b1);
            #1;
            total++; if (illegal_branch !== 1'b1) begin bad++; $display("FAIL illegal_flag[%0d] got=%b exp=1", k, illegal_branch); end
            total++; if (actual_taken !== 1'b0) begin bad++; $display("FAIL illegal_taken[%0d] got=%b exp=0", k, actual_taken); end
            total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL illegal_mispredict[%0d] got=%b exp=0", k, mispredict); end
            tick();
            total++; if (pred_taken_f !== model_pred(32'h40)) begin bad++; $display("FAIL illegal_bht[%0d] got=%b exp=%b", k, pred_taken_f, model_pred(32'h40)); end
        end
        idle();
    endtask

    task automatic test_jal();
        // jal alone on a weakly-not-taken entry must not train it up.
        pc_f = 32'h80;
        drive(1'b1, 32'h80, 32'h1234, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL jal_mispredict got=%b exp=1", mispredict); end
        total++; if (redirect_pc !== 32'h1234) begin bad++; $display("FAIL jal_redirect got=%h exp=00001234", redirect_pc); end
        tick();
        total++; if (pred_taken_f !== model_pred(32'h80)) begin bad++; $display("FAIL jal_bht got=%b exp=%b", pred_taken_f, model_pred(32'h80)); end
        // jump and a not-taken bne together: jump wins, no training of the 10 counter at 0x40.
        pc_f = 32'h40;
        drive(1'b1, 32'h40, 32'h500, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (actual_taken !== 1'b1) begin bad++; $display("FAIL jump_prio_taken got=%b exp=1", actual_taken); end
        tick();
        total++; if (pred_taken_f !== model_pred(32'h40)) begin bad++; $display("FAIL jump_prio_bht got=%b exp=%b", pred_taken_f, model_pred(32'h40)); end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        pc_f = 32'h100;
        #1;
        total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL reset_mid_pre got=%b exp=1", pred_taken_f); end
        reset = 1'b1;
        model_reset();
        #1;
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL reset_mid_async got=%b exp=0", pred_taken_f); end
        tick();
        reset = 1'b0;
        idle();
        for (int i = 0; i < NENT; i++) begin
            pc_f = 32'(i * 4);
            #1;
            total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL reset_mid_entry[%0d] got=%b exp=0", i, pred_taken_f); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rs1, rs2, pc, tgt, exp_redir;
        logic [2:0]  f3;
        logic        rv, br, jp, pe, z, lt, ult;
        bit          active, e_ill, e_act, e_mis;
        for (int n = 0; n < 400; n++) begin
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            z = (rs1 == rs2);
            lt = ($signed(rs1) < $signed(rs2));
            ult = (rs1 < rs2);
            f3 = 3'($urandom_range(0, 7));
            rv = ($urandom_range(0, 7) != 0);
            br = ($urandom_range(0, 3) != 0);
            jp = ($urandom_range(0, 5) == 0);
            pe = 1'($urandom_range(0, 1));
            pc = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_00FC);
            tgt = $urandom;
            pc_f = ($urandom_range(0, 1) == 0) ? $urandom : pc;
            drive(rv, pc, tgt, br, jp, f3, z, lt, ult, pe);
            active = rv && (br || jp);
            e_ill = active && !jp && !is_legal(f3);
            e_act = active && (jp || (is_legal(f3) && outcome(f3, z, lt, ult)));
            e_mis = active && !e_ill && (e_act != pe);
            exp_redir = e_act ? tgt : pc + 32'd4;
            #1;
            total++; if (pred_taken_f !== model_pred(pc_f)) begin bad++; $display("FAIL rnd_pred[%0d] got=%b exp=%b", n, pred_taken_f, model_pred(pc_f)); end
            total++; if (actual_taken !== e_act) begin bad++; $display("FAIL rnd_taken[%0d] got=%b exp=%b", n, actual_taken, e_act); end
            total++; if (mispredict !== e_mis) begin bad++; $display("FAIL rnd_mispredict[%0d] got=%b exp=%b", n, mispredict, e_mis); end
            total++; if (illegal_branch !== e_ill) begin bad++; $display("FAIL rnd_illegal[%0d] got=%b exp=%b", n, illegal_branch, e_ill); end
            if (e_mis) begin
                total++; if (redirect_pc !== exp_redir) begin bad++; $display("FAIL rnd_redirect[%0d] got=%h exp=%h", n, redirect_pc, exp_redir); end
            end
            tick();
        end
        idle();
        for (int i = 0; i < NENT; i++) begin
            pc_f = 32'(i * 4);
            #1;
            total++; if (pred_taken_f !== model_pred(pc_f)) begin bad++; $display("FAIL sweep_entry[%0d] got=%b exp=%b", i, pred_taken_f, model_pred(pc_f)); end
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        total++; if (branch_count !== 32'd0) begin bad++; $display("FAIL stats_clr0_branch got=%0d exp=0", branch_count); end
        for (int k = 0; k < 5; k++) begin
            // first three taken beq predicted taken, last two not-taken beq predicted taken
            drive(1'b1, 32'h300, 32'h400, 1'b1, 1'b0, 3'b000, (k < 3), 1'b0, 1'b0, 1'b1);
            tick();
        end
        idle();
        #1;
        total++; if (branch_count !== 32'd5) begin bad++; $display("FAIL stats_branch got=%0d exp=5", branch_count); end
        total++; if (mispredict_count !== 32'd2) begin bad++; $display("FAIL stats_mispredict got=%0d exp=2", mispredict_count); end
        stats_clr = 1'b1;
        drive(1'b1, 32'h300, 32'h400, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        stats_clr = 1'b0;
        idle();
        total++; if (branch_count !== 32'd0) begin bad++; $display("FAIL stats_clr_branch got=%0d exp=0", branch_count); end
        total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL stats_clr_mispredict got=%0d exp=0", mispredict_count); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        pc_f = '0;
`ifdef BRANCH_STATS_EN
        stats_clr = 1'b0;
`endif
        idle();
        test_reset();
        test_beq_saturate();
        test_bge();
        test_bltu_wrap();
        test_same_cycle();
        test_illegal();
        test_jal();
        test_reset_mid();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
